// File: rtl/nibble_sorter_pkg.sv
// Shared definitions for the nibble sorter: state encoding and default sizing.
package nibble_sorter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_N     = 4;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_compare.sv
// Unsigned magnitude comparator with one-hot greater / less / equal flags.
module nibble_compare #(
    parameter int WIDTH = nibble_sorter_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    always_comb begin
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/nibble_sorter4.sv
// Load / bubble-sort / drain sequencer sharing one comparator over an N-entry buffer.
module nibble_sorter4
    import nibble_sorter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int             IW       = $clog2(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0]  LAST_CMP = IW'(N - 2);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q [N];
    logic [WIDTH-1:0]  data_d [N];
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     pass_q, pass_d;
    logic              swapped_q, swapped_d;

    logic [IW-1:0]     i_nxt;
    logic [WIDTH-1:0]  cmp_a;
    logic [WIDTH-1:0]  cmp_b;
    logic              cmp_gt;
    logic              cmp_lt_unused;
    logic              cmp_eq_unused;
    logic              swap_any;

    assign i_nxt = i_q + 1'b1;
    assign cmp_a = data_q[i_q];
    assign cmp_b = data_q[i_nxt];

    nibble_compare #(.WIDTH(WIDTH)) u_compare (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (cmp_gt),
        .lt (cmp_lt_unused),
        .eq (cmp_eq_unused)
    );

    // Strict greater-than drives the swap, so equal neighbours keep their order.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        i_d       = i_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        swap_any  = swapped_q | cmp_gt;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    data_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = S_SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            S_SORT: begin
                if (cmp_gt) begin
                    data_d[i_q]   = cmp_b;
                    data_d[i_nxt] = cmp_a;
                end
                if (i_q == LAST_CMP) begin
                    i_d       = '0;
                    swapped_d = 1'b0;
                    if (!swap_any || pass_q == LAST_CMP) begin
                        pass_d  = '0;
                        state_d = S_OUT;
                    end else begin
                        pass_d = pass_q + 1'b1;
                    end
                end else begin
                    i_d       = i_nxt;
                    swapped_d = swap_any;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d  = '0;
                        wr_idx_d  = '0;
                        i_d       = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                        state_d   = S_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LOAD;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            i_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            i_q       <= i_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            data_q    <= data_d;
        end
    end

    // Handshake outputs decode registered state only; reset forces them low.
    always_comb begin
        in_ready  = !rst && (state_q == S_LOAD);
        out_valid = !rst && (state_q == S_OUT);
        busy      = !rst && (state_q != S_LOAD);
        out_last  = out_valid && (rd_idx_q == LAST_IDX);
        out_data  = out_valid ? data_q[rd_idx_q] : '0;
    end

endmodule

// File: tb/tb_nibble_sorter4.sv
// Table-driven, scoreboarded bench for nibble_sorter4 plus a sweep of nibble_compare.
module tb_nibble_sorter4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;

    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic       cmp_gt;
    logic       cmp_lt;
    logic       cmp_eq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0][3:0] vals;
        logic [3:0][3:0] sorted;
        int              sort_cycles;
        int              gap;
        bit              stress;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    nibble_sorter4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    nibble_compare #(.WIDTH(4)) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load one frame (optionally with gaps) and queue its expected sorted output.
    task automatic applyStimulus(input logic [3:0][3:0] vals, input logic [3:0][3:0] sorted,
                                 input int gap, input bit stress);
        int wait_cnt;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 4'hA;
                step();
            end
            in_valid = 1'b1;
            in_data  = vals[k];
            wait_cnt = 0;
            while (!in_ready && wait_cnt < 50) begin
                step();
                wait_cnt++;
            end
            if (!in_ready) checkOutput("load_ready_timeout", 0, 1);
            step();
        end
        in_valid = stress;
        in_data  = 4'hA;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{data: sorted[k], last: (k == 3)});
        end
    endtask

    task automatic waitSort(input int expected_cycles);
        int cnt = 0;
        checkOutput("in_ready_in_sort", int'(in_ready), 0);
        checkOutput("busy_in_sort", int'(busy), 1);
        while (!out_valid && cnt < 100) begin
            step();
            cnt++;
        end
        if (!out_valid) checkOutput("sort_timeout", 0, 1);
        if (expected_cycles >= 0) checkOutput("sort_cycles", cnt, expected_cycles);
    endtask

    task automatic drainFrame(input bit toggle);
        int         sent = 0;
        int         cyc  = 0;
        bit         stalled = 1'b0;
        logic [4:0] held = '0;
        bit         pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_t       e;
        while (sent < 4 && cyc < 200) begin
            out_ready = toggle ? pattern[cyc % 4] : 1'b1;
            if (out_valid) begin
                checkOutput("in_ready_in_out", int'(in_ready), 0);
                if (stalled) checkOutput("stall_hold", int'({out_last, out_data}), int'(held));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("scoreboard_empty", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("out_data", int'(out_data), int'(e.data));
                        checkOutput("out_last", int'(out_last), int'(e.last));
                    end
                    sent++;
                    stalled = 1'b0;
                end else begin
                    held    = {out_last, out_data};
                    stalled = 1'b1;
                end
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (sent < 4) checkOutput("drain_timeout", sent, 4);
        checkOutput("turnaround_in_ready", int'(in_ready), 1);
        checkOutput("turnaround_busy", int'(busy), 0);
        checkOutput("turnaround_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cmp_a     = '0;
        cmp_b     = '0;

        vecs[0] = '{vals: {4'd0, 4'd3, 4'd3, 4'd9},  sorted: {4'd9, 4'd3, 4'd3, 4'd0},
                    sort_cycles: 9, gap: 0, stress: 1'b0};
        vecs[1] = '{vals: {4'd4, 4'd3, 4'd2, 4'd1},  sorted: {4'd4, 4'd3, 4'd2, 4'd1},
                    sort_cycles: 3, gap: 0, stress: 1'b0};
        vecs[2] = '{vals: {4'd7, 4'd7, 4'd7, 4'd7},  sorted: {4'd7, 4'd7, 4'd7, 4'd7},
                    sort_cycles: 3, gap: 0, stress: 1'b0};
        vecs[3] = '{vals: {4'd12, 4'd13, 4'd14, 4'd15}, sorted: {4'd15, 4'd14, 4'd13, 4'd12},
                    sort_cycles: 9, gap: 2, stress: 1'b1};
        vecs[4] = '{vals: {4'd8, 4'd8, 4'd15, 4'd0}, sorted: {4'd15, 4'd8, 4'd8, 4'd0},
                    sort_cycles: 6, gap: 1, stress: 1'b0};

        for (int p = 0; p < 256; p++) begin
            cmp_a = 4'(p >> 4);
            cmp_b = 4'(p);
            #1;
            checkOutput("cmp_flags", int'({cmp_gt, cmp_lt, cmp_eq}),
                        (p >> 4) > (p & 15) ? 4 : ((p >> 4) < (p & 15) ? 2 : 1));
        end

        step();
        step();
        checkOutput("reset_in_ready", int'(in_ready), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_out_last", int'(out_last), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 5; v++) begin
            $display("[TB] frame %0d", v);
            applyStimulus(vecs[v].vals, vecs[v].sorted, vecs[v].gap, vecs[v].stress);
            waitSort(vecs[v].sort_cycles);
            drainFrame(vecs[v].stress);
        end

        $display("[TB] reset during sort");
        applyStimulus({4'd0, 4'd3, 4'd3, 4'd9}, {4'd9, 4'd3, 4'd3, 4'd0}, 0, 1'b0);
        step();
        step();
        step();
        checkOutput("mid_sort_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        checkOutput("in_rst_in_ready", int'(in_ready), 0);
        checkOutput("in_rst_out_valid", int'(out_valid), 0);
        checkOutput("in_rst_busy", int'(busy), 0);
        checkOutput("in_rst_out_data", int'(out_data), 0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("after_rst_in_ready", int'(in_ready), 1);
        checkOutput("after_rst_out_valid", int'(out_valid), 0);
        checkOutput("after_rst_busy", int'(busy), 0);
        applyStimulus({4'd0, 4'd1, 4'd0, 4'd2}, {4'd2, 4'd1, 4'd0, 4'd0}, 0, 1'b0);
        waitSort(9);
        drainFrame(1'b0);

        $display("[TB] back-to-back frames");
        applyStimulus({4'd1, 4'd6, 4'd1, 4'd8}, {4'd8, 4'd6, 4'd1, 4'd1}, 0, 1'b0);
        waitSort(9);
        drainFrame(1'b0);
        applyStimulus({4'd2, 4'd3, 4'd4, 4'd5}, {4'd5, 4'd4, 4'd3, 4'd2}, 0, 1'b0);
        waitSort(9);
        drainFrame(1'b0);
        checkOutput("scoreboard_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_sorter4.md
# nibble_sorter4

Sequencer that shares a single 4-bit magnitude comparator across a four-entry register file to sort nibbles in ascending order. Values stream in over a valid/ready handshake. The block runs an early-exit bubble sort, one compare-and-swap per cycle. The sorted values stream out over a second valid/ready handshake. It sits between a nibble producer and any consumer that needs ordered data, such as min/max or median extraction.

## Interface
- `WIDTH`, default 4: data width per element.
- `N`, default 4: element count, N >= 2. Sized for N = 4; larger N only lengthens counters.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: input element present.
- `in_ready` out 1: block accepts an input element this cycle.
- `in_data` in WIDTH: input element.
- `out_valid` out 1: output element present.
- `out_ready` in 1: consumer accepts the output element.
- `out_data` out WIDTH: output element, ascending order.
- `out_last` out 1: high with the N-th output element.
- `busy` out 1: high in SORT or OUT.

## Operation
- **States.**
  - LOAD: fill the buffer.
  - SORT: compare and swap.
  - OUT: drain the buffer.
  - Reset state is LOAD.
- **Reset.** State = LOAD, all counters = 0, and every buffer entry = 0.
  - While `rst` is high: `in_ready`, `out_valid`, `out_last`, `busy` and `out_data` are all 0.
- **LOAD.**
  - `in_ready` = 1.
  - Each transfer (`in_valid && in_ready`) writes `buf[wr_idx]` and increments `wr_idx`.
  - On the N-th transfer, `wr_idx` returns to 0 and the next state is SORT.
  - Gaps in `in_valid` are allowed.
- **SORT.**
  - `in_ready` = 0, so `in_valid` is ignored.
  - Each cycle compares `buf[i]` (A) with `buf[i+1]` (B).
  - If A > B (strict), the two entries are swapped at the clock edge and `swapped_flag` is set.
  - Equal values are never swapped, so the sort is stable.
  - `i` counts 0..N-2.
- **End of pass** (compare at `i` = N-2):
  - If no swap occurred anywhere in the pass, including this compare, the next state is OUT.
  - Otherwise, if `pass` = N-2, the next state is OUT.
  - Otherwise `i` = 0, `pass` increments, and `swapped_flag` clears.
- **OUT.**
  - `out_valid` = 1 and `out_data` = `buf[rd_idx]`.
  - `out_last` = 1 when `rd_idx` = N-1.
  - Each transfer increments `rd_idx`.
  - After the transfer with `out_last`, the next state is LOAD and all counters are cleared.
  - Buffer contents are not cleared; they are overwritten by the next load.
- **Arithmetic.** Comparison is unsigned across WIDTH bits. Counters are sized `$clog2(N)` (plus 1 where the count reaches N); none of them wraps.

## Timing
- **Load:** at least N cycles; exactly N cycles with `in_valid` held high.
- **Sort:** between N-1 cycles (input already sorted) and (N-1)^2 cycles (worst case). For N = 4 that is 3 to 9 cycles.
- **Drain:** at least N cycles; exactly N with `out_ready` held high.
- **Turnaround:** `in_ready` = 1 in the cycle after the last output transfer. There are no dead cycles between states.
- **Backpressure hold:** while `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- **Outputs are state decodes:** `in_ready`, `out_valid` and `busy` come from registered state, gated only by `rst`. There is no combinational path from `in_valid` or `out_ready` to any output.
- **Reset mid-operation:** `rst` in any state, for any cycle, yields LOAD with cleared counters in the following cycle. No partial output is emitted afterwards.

## Structure
- **Shared package / header `nibble_sorter_pkg`:**
  - state encoding localparams `S_LOAD`, `S_SORT`, `S_OUT`;
  - defaults for `WIDTH` and `N`.
- **Sub-module `nibble_compare`:**
  - purely combinational;
  - inputs A[WIDTH-1:0] and B[WIDTH-1:0];
  - one-hot outputs `gt`, `lt`, `eq`, exactly one high for every input pair.
  - The sorter instantiates it once and uses `gt` as the swap enable.
  - It has its own unit bench with an exhaustive 256-pair sweep.

## Test plan
- **Unsorted with duplicates.** Load 9, 3, 3, 0.
  - SORT lasts exactly 9 cycles.
  - Output is 0, 3, 3, 9, with `out_last` only on 9.
- **Already sorted.** Load 1, 2, 3, 4.
  - SORT lasts 3 cycles (early exit).
  - Output is 1, 2, 3, 4.
- **All equal.** Load 7, 7, 7, 7.
  - No swaps; SORT lasts 3 cycles.
  - Output is four 7s.
- **Handshake stress.** Load 15, 14, 13, 12 with `in_valid` gaps, then drain with `out_ready` toggling 1, 0, 0, 1, ...
  - Output is 12, 13, 14, 15.
  - `out_data` is stable during stalls.
  - `in_valid` is ignored while `busy`.
- **Reset mid-sort.** Assert `rst` for 1 cycle during the 4th SORT cycle.
  - Next cycle: `in_ready` = 1, `out_valid` = 0, `busy` = 0.
  - A fresh load of 2, 0, 1, 0 outputs 0, 0, 1, 2.
- **Back-to-back frames.** Last output transfer, then `in_ready` = 1 in the following cycle.
  - A second frame loads 5, 4, 3, 2 immediately and outputs 2, 3, 4, 5.
